// File: rtl/io_pkg.sv
// io_pkg: FSM encoding and IO register map shared by the arbiter and the peripheral block.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    localparam logic [7:0] IO_CTRL   = 8'h00;
    localparam logic [7:0] IO_STATUS = 8'h01;
    localparam logic [7:0] IO_DATA   = 8'h02;
    localparam logic [7:0] IO_IRQ    = 8'h03;

    function automatic state_e lock_state(input logic m);
        return m ? LOCK1 : LOCK0;
    endfunction

endpackage

// File: rtl/io_arb_rr.sv
// io_arb_rr: two-way round-robin pick; on a tie the master not granted last wins.
module io_arb_rr (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o[0] = req_i[0] & (~req_i[1] | last_i);
        gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);
    end

endmodule

// File: rtl/io_arbiter.sv
// io_arbiter: two-master IO bus arbiter with round-robin ties, bounded lock ownership and pipelined reads.
module io_arbiter
    import io_pkg::*;
#(
    parameter int MAX_LOCK = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m0_req,
    input  logic       m0_we,
    input  logic       m0_lock,
    input  logic [7:0] m0_addr,
    input  logic [7:0] m0_wdata,
    output logic       m0_gnt,
    output logic       m0_rvalid,
    output logic [7:0] m0_rdata,
    input  logic       m1_req,
    input  logic       m1_we,
    input  logic       m1_lock,
    input  logic [7:0] m1_addr,
    input  logic [7:0] m1_wdata,
    output logic       m1_gnt,
    output logic       m1_rvalid,
    output logic [7:0] m1_rdata,
    output logic [7:0] io_address,
    output logic [7:0] io_din,
    output logic       io_w_en,
    output logic       io_r_en,
    input  logic [7:0] io_dout
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_LOCK);

    state_e        state_q, state_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          last_q;
    logic [1:0]    rvalid_q;
    logic [7:0]    rdata0_q, rdata1_q;

    logic [1:0] req, lock, we, elig, pick, gnt;
    logic       locked, own, cap, any, g;

    always_comb begin
        req    = {m1_req, m0_req};
        lock   = {m1_lock, m0_lock};
        we     = {m1_we, m0_we};
        locked = state_q != IDLE;
        own    = state_q == LOCK1;
        cap    = lock_cnt_q >= MAX_C;
        // The owner is exclusive until the cap; at the cap a waiting master takes over.
        elig   = !locked ? req
               : (req[own] && !cap) ? 2'b01 << own
               : req[~own] ? 2'b01 << ~own
               : req;
    end

    io_arb_rr u_rr (
        .req_i  (elig),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    always_comb begin
        gnt        = rst ? 2'b00 : pick;
        any        = |gnt;
        g          = gnt[1];
        io_address = !any ? 8'h00 : g ? m1_addr : m0_addr;
        io_din     = !any ? 8'h00 : g ? m1_wdata : m0_wdata;
        io_w_en    = any & we[g];
        io_r_en    = any & ~we[g];
        state_d    = (any && lock[g]) ? lock_state(g) : IDLE;
        lock_cnt_d = !(any && lock[g]) ? '0
                   : !locked ? CW'(1)
                   : (g != own) ? '0
                   : cap ? lock_cnt_q
                   : lock_cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
            last_q     <= 1'b1;
            rvalid_q   <= 2'b00;
            rdata0_q   <= 8'h00;
            rdata1_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            if (any) last_q <= g;
            rvalid_q   <= gnt & ~we;
            if (rvalid_q[0]) rdata0_q <= io_dout;
            if (rvalid_q[1]) rdata1_q <= io_dout;
        end
    end

    // Reset masks in-flight read returns so a read granted just before rst is dropped.
    always_comb begin
        m0_gnt    = gnt[0];
        m1_gnt    = gnt[1];
        m0_rvalid = rvalid_q[0] & ~rst;
        m1_rvalid = rvalid_q[1] & ~rst;
        m0_rdata  = rst ? 8'h00 : rvalid_q[0] ? io_dout : rdata0_q;
        m1_rdata  = rst ? 8'h00 : rvalid_q[1] ? io_dout : rdata1_q;
    end

endmodule

// File: tb/tb_io_arbiter.sv
// tb_io_arbiter: directed checks of arbitration, locking, read pipeline and reset behaviour.
module tb_io_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
    logic       m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [7:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [7:0] io_address, io_din, io_dout;
    logic       io_w_en, io_r_en;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    io_arbiter #(.MAX_LOCK(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .io_address(io_address), .io_din(io_din), .io_w_en(io_w_en), .io_r_en(io_r_en),
        .io_dout(io_dout)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #4;
    endtask

    bit e0 [7] = '{0, 0, 0, 0, 1, 0, 0};
    bit e1 [7] = '{1, 1, 1, 1, 0, 1, 1};

    initial begin
        bit p0, p1;
        rst = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h00;
        m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = 8'h00; m1_wdata = 8'h00;
        io_dout = 8'h00;
        tick;
        settle;
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_io_r_en", io_r_en, 0);
        chk("rst_io_w_en", io_w_en, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m0_rdata", m0_rdata, 8'h00);
        chk("rst_m1_rdata", m1_rdata, 8'h00);
        tick;

        rst = 1'b0; m0_addr = 8'h01; m1_addr = 8'h02;
        settle;
        chk("c1_m0_gnt", m0_gnt, 1);
        chk("c1_m1_gnt", m1_gnt, 0);
        chk("c1_io_address", io_address, 8'h01);
        chk("c1_io_r_en", io_r_en, 1);
        tick;
        m0_req = 1'b0; io_dout = 8'hC1;
        settle;
        chk("c2_m0_rvalid", m0_rvalid, 1);
        chk("c2_m0_rdata", m0_rdata, 8'hC1);
        chk("c2_m1_gnt", m1_gnt, 1);
        chk("c2_io_address", io_address, 8'h02);
        tick;
        m1_req = 1'b0; io_dout = 8'hC2;
        settle;
        chk("c3_m1_rvalid", m1_rvalid, 1);
        chk("c3_m1_rdata", m1_rdata, 8'hC2);
        chk("c3_m0_rvalid", m0_rvalid, 0);
        chk("c3_m0_rdata_hold", m0_rdata, 8'hC1);
        chk("c3_m1_gnt", m1_gnt, 0);
        tick;

        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h00; m0_wdata = 8'hA5; io_dout = 8'h77;
        settle;
        chk("wr_m0_gnt", m0_gnt, 1);
        chk("wr_io_w_en", io_w_en, 1);
        chk("wr_io_r_en", io_r_en, 0);
        chk("wr_io_address", io_address, 8'h00);
        chk("wr_io_din", io_din, 8'hA5);
        chk("wr_m1_rdata_hold", m1_rdata, 8'hC2);
        tick;
        m0_req = 1'b0;
        settle;
        chk("wr_m0_rvalid", m0_rvalid, 0);
        chk("idle_io_w_en", io_w_en, 0);
        chk("idle_io_address", io_address, 8'h00);
        chk("idle_io_din", io_din, 8'h00);
        tick;

        m0_we = 1'b0; m0_addr = 8'h20; m1_addr = 8'h10; m1_lock = 1'b1;
        p0 = 0; p1 = 0;
        for (int i = 0; i < 7; i++) begin
            m0_req = (i < 5); m1_req = 1'b1; io_dout = 8'h30 + 8'(i);
            settle;
            chk($sformatf("lock_m0_gnt_%0d", i), m0_gnt, e0[i]);
            chk($sformatf("lock_m1_gnt_%0d", i), m1_gnt, e1[i]);
            chk($sformatf("lock_m0_rvalid_%0d", i), m0_rvalid, p0);
            chk($sformatf("lock_m1_rvalid_%0d", i), m1_rvalid, p1);
            p0 = e0[i]; p1 = e1[i];
            tick;
        end
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0; io_dout = 8'h3F;
        settle;
        chk("lock_end_m1_rvalid", m1_rvalid, 1);
        chk("lock_end_m1_rdata", m1_rdata, 8'h3F);
        chk("lock_end_m0_rdata", m0_rdata, 8'h35);
        chk("lock_end_m1_gnt", m1_gnt, 0);
        tick;

        m0_we = 1'b1; m1_we = 1'b1; m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            settle;
            chk($sformatf("alt_m0_gnt_%0d", i), m0_gnt, (i % 2) == 0);
            chk($sformatf("alt_m1_gnt_%0d", i), m1_gnt, (i % 2) == 1);
            chk($sformatf("alt_io_w_en_%0d", i), io_w_en, 1);
            tick;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        settle;
        chk("alt_end_io_w_en", io_w_en, 0);
        tick;

        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h44; m1_we = 1'b0;
        settle;
        chk("rr_m0_gnt", m0_gnt, 1);
        chk("rr_io_r_en", io_r_en, 1);
        tick;
        rst = 1'b1; m0_req = 1'b0; m1_req = 1'b1; io_dout = 8'h99;
        settle;
        chk("rr_rst_m0_rvalid", m0_rvalid, 0);
        chk("rr_rst_m0_rdata", m0_rdata, 8'h00);
        chk("rr_rst_m1_gnt", m1_gnt, 0);
        tick;
        rst = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
        settle;
        chk("rr_post_m0_rvalid", m0_rvalid, 0);
        chk("rr_post_m0_gnt", m0_gnt, 1);
        chk("rr_post_m1_gnt", m1_gnt, 0);
        tick;
        m0_req = 1'b0; m1_req = 1'b0;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_arbiter.md
IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 SHALL have parameter MAX_LOCK, default 4: max consecutive locked grants to one master while the other master waits.
REQ-002 SHALL have port clk  input  1: sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-004 SHALL have port mN_req  input  1 (N=0,1): master N requests one IO access.
REQ-005 SHALL have port mN_we  input  1: 1 = write, 0 = read.
REQ-006 SHALL have port mN_lock  input  1: master N asks to keep ownership for its next access.
REQ-007 SHALL have port mN_addr  input  8: IO register address.
REQ-008 SHALL have port mN_wdata  input  8: write data.
REQ-009 SHALL have port mN_gnt  output  1: access accepted this cycle.
REQ-010 SHALL have port mN_rvalid  output  1: read data valid this cycle.
REQ-011 SHALL have port mN_rdata  output  8: read data.
REQ-012 SHALL have port io_address  output  8: address to the IO peripheral block.
REQ-013 SHALL have port io_din  output  8: write data to the IO peripheral block.
REQ-014 SHALL have port io_w_en  output  1: write strobe.
REQ-015 SHALL have port io_r_en  output  1: read strobe.
REQ-016 SHALL have port io_dout  input  8: peripheral read data, valid one cycle after io_r_en.

Function
REQ-017 SHALL accept at most one access per cycle; an access is accepted when mN_req & mN_gnt.
REQ-018 SHALL drive mN_gnt combinationally in the request cycle; it SHALL never assert gnt without req, nor both gnts together.
REQ-019 SHALL drive io_address/io_din/io_w_en/io_r_en combinationally from the granted master in the grant cycle; with no grant, io_w_en = io_r_en = 0 and io_address/io_din = 0.
REQ-020 SHALL assert mN_rvalid exactly one cycle after a granted read by master N, with mN_rdata = io_dout; writes produce no rvalid.
REQ-021 SHALL be fully pipelined: a new grant may occur in the same cycle as the previous read's rvalid.
REQ-022 SHALL hold mN_rdata at its last value while mN_rvalid = 0.
REQ-023 FSM states IDLE, LOCK0, LOCK1; SHALL enter LOCKn when master n is granted with mN_lock = 1.
REQ-024 In IDLE with both requesting, SHALL grant the master not granted most recently (round-robin pointer, updated on every grant).
REQ-025 In LOCKn, SHALL grant master n whenever it requests and lock_cnt < MAX_LOCK; the other master SHALL be granted only if master n is not requesting.
REQ-026 lock_cnt SHALL increment on each locked grant, saturate at MAX_LOCK, and clear on a grant switch or when the owner is granted with lock = 0 (return to IDLE).
REQ-027 When lock_cnt = MAX_LOCK and the other master requests, SHALL grant the other master, clear lock_cnt, and move to IDLE or LOCK(other) per its lock bit.
REQ-028 LOCKn SHALL return to IDLE in any cycle master n does not request.

Reset
REQ-029 While rst = 1: all gnt, rvalid, io_w_en, io_r_en = 0; rdata = 0; state = IDLE; lock_cnt = 0; pointer set so m0 wins the first tie.
REQ-030 A read granted in the cycle before rst asserts SHALL NOT produce rvalid.

Structure
REQ-031 Package io_pkg SHALL hold the FSM state encoding and IO register address constants shared with the peripheral block.
REQ-032 The two-way round-robin pick SHALL be one sub-module, io_arb_rr; the lock counter and FSM stay in io_arbiter.

Verification
REQ-033 Both masters read at once after reset (m0 addr 0x01, m1 addr 0x02) -> m0_gnt cycle 1, m0_rvalid cycle 2; m1_gnt cycle 2, m1_rvalid cycle 3.
REQ-034 m0 writes 0xA5 to 0x00 -> io_w_en = 1, io_address = 0x00, io_din = 0xA5 in the grant cycle; no rvalid.
REQ-035 m1 holds lock = 1 with 6 back-to-back reads while m0 requests, MAX_LOCK = 4 -> m1 granted 4 times, then m0 granted, then m1 resumes.
REQ-036 Continuous requests from both, lock = 0 -> grants alternate m0, m1, m0, ...; exactly one gnt per cycle.
REQ-037 rst asserted the cycle after m0 read grant -> m0_rvalid stays 0; first post-reset tie goes to m0.
